// File: rtl/sdram_bist_master_if.sv
// User-side bus between the BIST initiator and the SDRAM driver:
// write command/data channel, read command channel and read-response channel.
interface sdram_bist_master_if #(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 16
);
  logic                  reader_valid;
  logic                  reader_ready;
  logic [ADDR_WIDTH-1:0] reader_addr;
  logic                  writer_valid;
  logic                  writer_ready;
  logic [ADDR_WIDTH-1:0] writer_addr;
  logic [DATA_WIDTH-1:0] writer_data;
  logic                  resp_valid;
  logic                  resp_last;
  logic [DATA_WIDTH-1:0] resp_data;
  logic                  resp_ready;

  modport master (
    output reader_valid, reader_addr,
    input  reader_ready,
    output writer_valid, writer_addr, writer_data,
    input  writer_ready,
    input  resp_valid, resp_last, resp_data,
    output resp_ready
  );

  modport slave (
    input  reader_valid, reader_addr,
    output reader_ready,
    input  writer_valid, writer_addr, writer_data,
    output writer_ready,
    output resp_valid, resp_last, resp_data,
    input  resp_ready
  );
endinterface

// File: rtl/sdram_bist_master.sv
// Memory self-test initiator: writes NUM_BURSTS bursts of an address^seed
// pattern, reads them back, and reports error count and first failing address.
module sdram_bist_master #(
  parameter int ADDR_WIDTH   = 24,
  parameter int DATA_WIDTH   = 16,
  parameter int BURST_LENGTH = 8,
  parameter int NUM_BURSTS   = 16,
  parameter int ERR_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [DATA_WIDTH-1:0] seed,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_WIDTH-1:0]  err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic                  proto_err,
  sdram_bist_master_if.master   bus
);

  localparam int BEAT_W  = (BURST_LENGTH > 1) ? $clog2(BURST_LENGTH) : 1;
  localparam int BURST_W = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
  localparam logic [BEAT_W-1:0]     LAST_BEAT    = BEAT_W'(BURST_LENGTH - 1);
  localparam logic [BURST_W-1:0]    LAST_BURST   = BURST_W'(NUM_BURSTS - 1);
  localparam logic [ADDR_WIDTH-1:0] BURST_STRIDE = ADDR_WIDTH'(BURST_LENGTH);

  typedef enum logic [2:0] {
    IDLE, WR_CMD, WR_DATA, RD_CMD, RD_DATA, FINISH
  } state_t;

  state_t                state_q, state_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [BURST_W-1:0]    burst_q, burst_d;
  logic [ADDR_WIDTH-1:0] burst_addr_q, burst_addr_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [DATA_WIDTH-1:0] seed_q, seed_d;
  logic [ERR_WIDTH-1:0]  err_q, err_d;
  logic [ADDR_WIDTH-1:0] first_q, first_d;
  logic                  proto_q, proto_d;
  logic                  pass_q, pass_d;

  logic [ADDR_WIDTH-1:0] word_addr;
  logic [DATA_WIDTH-1:0] pattern;
  logic                  beat_is_last;

  // burst_addr is tracked incrementally so the address path is a single adder
  assign word_addr    = burst_addr_q + ADDR_WIDTH'(beat_q);
  assign beat_is_last = (beat_q == LAST_BEAT);

  generate
    if (ADDR_WIDTH >= DATA_WIDTH) begin : g_pat_trunc
      assign pattern = word_addr[DATA_WIDTH-1:0] ^ seed_q;
    end else begin : g_pat_zext
      assign pattern = {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, word_addr} ^ seed_q;
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    burst_d      = burst_q;
    burst_addr_d = burst_addr_q;
    base_d       = base_q;
    seed_d       = seed_q;
    err_d        = err_q;
    first_d      = first_q;
    proto_d      = proto_q;
    pass_d       = pass_q;

    bus.writer_valid = 1'b0;
    bus.writer_addr  = '0;
    bus.writer_data  = '0;
    bus.reader_valid = 1'b0;
    bus.reader_addr  = '0;
    bus.resp_ready   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          base_d       = base_addr;
          seed_d       = seed;
          burst_addr_d = base_addr;
          err_d        = '0;
          first_d      = '0;
          proto_d      = 1'b0;
          pass_d       = 1'b0;
          burst_d      = '0;
          state_d      = WR_CMD;
        end
      end
      WR_CMD: begin
        bus.writer_valid = 1'b1;
        bus.writer_addr  = burst_addr_q;
        if (bus.writer_ready) begin
          beat_d  = '0;
          state_d = WR_DATA;
        end
      end
      WR_DATA: begin
        bus.writer_valid = 1'b1;
        bus.writer_addr  = burst_addr_q;
        bus.writer_data  = pattern;
        if (bus.writer_ready) begin
          beat_d = beat_q + 1'b1;
          if (beat_is_last) begin
            beat_d = '0;
            if (burst_q == LAST_BURST) begin
              burst_d      = '0;
              burst_addr_d = base_q;
              state_d      = RD_CMD;
            end else begin
              burst_d      = burst_q + 1'b1;
              burst_addr_d = burst_addr_q + BURST_STRIDE;
              state_d      = WR_CMD;
            end
          end
        end
      end
      RD_CMD: begin
        bus.reader_valid = 1'b1;
        bus.reader_addr  = burst_addr_q;
        if (bus.reader_ready) begin
          beat_d  = '0;
          state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        bus.resp_ready = 1'b1;
        if (bus.resp_valid) begin
          if (bus.resp_data != pattern) begin
            if (err_q == '0) first_d = word_addr;
            if (err_q != '1) err_d = err_q + 1'b1;
          end
          if (bus.resp_last != beat_is_last) proto_d = 1'b1;
          beat_d = beat_q + 1'b1;
          // burst length is fixed by the beat count; resp_last only feeds proto_err
          if (beat_is_last) begin
            beat_d = '0;
            if (burst_q == LAST_BURST) begin
              pass_d  = (err_d == '0) && !proto_d;
              state_d = FINISH;
            end else begin
              burst_d      = burst_q + 1'b1;
              burst_addr_d = burst_addr_q + BURST_STRIDE;
              state_d      = RD_CMD;
            end
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      burst_q      <= '0;
      burst_addr_q <= '0;
      base_q       <= '0;
      seed_q       <= '0;
      err_q        <= '0;
      first_q      <= '0;
      proto_q      <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      burst_q      <= burst_d;
      burst_addr_q <= burst_addr_d;
      base_q       <= base_d;
      seed_q       <= seed_d;
      err_q        <= err_d;
      first_q      <= first_d;
      proto_q      <= proto_d;
      pass_q       <= pass_d;
    end
  end

  assign busy           = (state_q != IDLE) && (state_q != FINISH);
  assign done           = (state_q == FINISH);
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = first_q;
  assign proto_err      = proto_q;

endmodule

// File: tb/tb_sdram_bist_master.sv
// Scoreboard bench: expected write beats and run results are queued at stimulus
// time and popped by a monitor on writer handshakes and done pulses.
module tb_sdram_bist_master;

  localparam int AW = 24;
  localparam int DW = 16;
  localparam int BL = 8;
  localparam int NB = 2;
  localparam int EW = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [DW-1:0] seed = '0;
  logic          busy, done, pass, proto_err;
  logic [EW-1:0] err_count;
  logic [AW-1:0] first_err_addr;

  sdram_bist_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  sdram_bist_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LENGTH(BL),
    .NUM_BURSTS(NB), .ERR_WIDTH(EW)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr), .seed(seed),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_addr(first_err_addr), .proto_err(proto_err), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          is_cmd;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_exp_t;

  typedef struct {
    logic          pass;
    logic [EW-1:0] errs;
    logic [AW-1:0] first;
    logic          proto;
    int            beats;
  } res_exp_t;

  wr_exp_t  wr_q[$];
  res_exp_t res_q[$];

  // driver-model knobs, written only by the stimulus process
  bit            stall_en = 0;
  bit            flip_en = 0;
  bit            bad_last = 0;
  logic [AW-1:0] flip_addr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] w, input logic [DW-1:0] s);
    return w[DW-1:0] ^ s;
  endfunction

  // Driver model: memory, write capture, one-cycle read response
  initial begin : driver
    logic [DW-1:0] mem [logic [AW-1:0]];
    logic [AW-1:0] wr_base, rd_addr, wa, ra, w;
    logic [DW-1:0] wd;
    int wr_beat, rd_beat, rd_idx;
    bit rd_active, wf, rf, pf;
    wr_beat = 0; rd_beat = 0; rd_idx = 0; rd_active = 0;
    wr_base = '0; rd_addr = '0;
    bus.writer_ready = 1'b0;
    bus.reader_ready = 1'b0;
    bus.resp_valid   = 1'b0;
    bus.resp_last    = 1'b0;
    bus.resp_data    = '0;
    forever begin
      @(negedge clk);
      wf = bus.writer_valid && bus.writer_ready;
      rf = bus.reader_valid && bus.reader_ready;
      pf = bus.resp_valid && bus.resp_ready;
      wa = bus.writer_addr; wd = bus.writer_data; ra = bus.reader_addr;
      @(posedge clk);
      #1;
      if (!rstn) begin
        wr_beat = 0; rd_active = 0; rd_idx = 0; rd_beat = 0;
        bus.writer_ready = 1'b0;
        bus.reader_ready = 1'b0;
        bus.resp_valid   = 1'b0;
        bus.resp_last    = 1'b0;
        bus.resp_data    = '0;
      end else begin
        if (wf) begin
          if (wr_beat == 0) wr_base = wa;
          else mem[wr_base + AW'(wr_beat - 1)] = wd;
          wr_beat = (wr_beat == BL) ? 0 : wr_beat + 1;
          rd_idx = 0;
        end
        if (pf) begin
          rd_beat++;
          if (rd_beat == BL) begin
            rd_active = 0;
            rd_idx++;
          end
        end
        if (rf) begin
          rd_addr = ra; rd_beat = 0; rd_active = 1;
        end
        bus.writer_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.reader_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.resp_valid   = rd_active;
        bus.resp_last    = 1'b0;
        bus.resp_data    = '0;
        if (rd_active) begin
          w = rd_addr + AW'(rd_beat);
          bus.resp_data = mem.exists(w) ? mem[w] : '0;
          if (flip_en && w == flip_addr) bus.resp_data[0] = ~bus.resp_data[0];
          bus.resp_last = (rd_beat == BL - 1) || (bad_last && rd_idx == 0 && rd_beat == 3);
        end
      end
    end
  end

  // Monitor: reset values, stall stability, write stream and run results
  initial begin : monitor
    bit            pv_w;
    logic [AW-1:0] pa;
    logic [DW-1:0] pd;
    int            beats;
    wr_exp_t       e;
    res_exp_t      r;
    pv_w = 0; beats = 0; pa = '0; pd = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        chk("rst_ctrl", {25'd0, busy, done, pass, proto_err,
                         bus.writer_valid, bus.reader_valid, bus.resp_ready}, 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_first_err_addr", 32'(first_err_addr), 32'd0);
        chk("rst_bus_addr", 32'(bus.writer_addr | bus.reader_addr), 32'd0);
        pv_w = 0; beats = 0;
      end else begin
        if (pv_w) begin
          chk("stall_valid", 32'(bus.writer_valid), 32'd1);
          chk("stall_addr", 32'(bus.writer_addr), 32'(pa));
          chk("stall_data", 32'(bus.writer_data), 32'(pd));
        end
        pv_w = bus.writer_valid && !bus.writer_ready;
        pa = bus.writer_addr; pd = bus.writer_data;
        if (bus.writer_valid && bus.writer_ready) begin
          checks++;
          if (wr_q.size() == 0) begin
            errors++;
            $display("FAIL wr_unexpected actual addr=%h data=%h required no beat",
                     bus.writer_addr, bus.writer_data);
          end else begin
            e = wr_q.pop_front();
            if (e.is_cmd) begin
              chk("wr_cmd_addr", 32'(bus.writer_addr), 32'(e.addr));
            end else begin
              chk("wr_data", 32'(bus.writer_data), 32'(e.data));
              chk("wr_data_addr_hold", 32'(bus.writer_addr), 32'(e.addr));
            end
          end
        end
        if (bus.resp_valid && bus.resp_ready) beats++;
        if (done) begin
          checks++;
          if (res_q.size() == 0) begin
            errors++;
            $display("FAIL done_unexpected actual done=1 required no done");
          end else begin
            r = res_q.pop_front();
            chk("pass", 32'(pass), 32'(r.pass));
            chk("err_count", 32'(err_count), 32'(r.errs));
            chk("first_err_addr", 32'(first_err_addr), 32'(r.first));
            chk("proto_err", 32'(proto_err), 32'(r.proto));
            chk("resp_beats", 32'(beats), 32'(r.beats));
            chk("busy_at_done", 32'(busy), 32'd0);
          end
          beats = 0;
        end
      end
    end
  end

  task automatic push_expect(input logic [AW-1:0] b, input logic [DW-1:0] s,
                             input logic ep, input logic [EW-1:0] ee,
                             input logic [AW-1:0] ef, input logic epr);
    logic [AW-1:0] ba;
    res_exp_t r;
    for (int i = 0; i < NB; i++) begin
      ba = b + AW'(i * BL);
      wr_q.push_back('{1'b1, ba, '0});
      for (int j = 0; j < BL; j++)
        wr_q.push_back('{1'b0, ba, pat(ba + AW'(j), s)});
    end
    r.pass = ep; r.errs = ee; r.first = ef; r.proto = epr; r.beats = NB * BL;
    res_q.push_back(r);
  endtask

  task automatic run(input logic [AW-1:0] b, input logic [DW-1:0] s, input int hold,
                     input logic ep, input logic [EW-1:0] ee,
                     input logic [AW-1:0] ef, input logic epr);
    bit seen;
    push_expect(b, s, ep, ee, ef, epr);
    @(posedge clk); #1;
    base_addr = b; seed = s; start = 1'b1;
    @(posedge clk); #1;
    chk("start_latency", {30'd0, busy, bus.writer_valid}, 32'd3);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
    end
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("done_seen", 32'(seen), 32'd1);
    repeat (4) @(negedge clk);
    chk("wr_queue_drained", 32'(wr_q.size()), 32'd0);
    chk("res_queue_drained", 32'(res_q.size()), 32'd0);
    chk("results_hold", {31'd0, pass}, 32'(ep));
    wr_q.delete();
    res_q.delete();
  endtask

  initial begin : stimulus
    bit reached;
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    // ideal driver, clean run
    run(24'h000100, 16'hA5A5, 0, 1'b1, 16'd0, 24'h0, 1'b0);

    // single bit flip on readback of 0x00010A
    flip_en = 1; flip_addr = 24'h00010A;
    run(24'h000100, 16'hA5A5, 0, 1'b0, 16'd1, 24'h00010A, 1'b0);
    flip_en = 0;

    // random back-pressure on writer and reader
    stall_en = 1;
    run(24'h001234, 16'hBEEF, 0, 1'b1, 16'd0, 24'h0, 1'b0);
    stall_en = 0;

    // address wrap at top of space
    run(24'hFFFFFC, 16'h3C3C, 0, 1'b1, 16'd0, 24'h0, 1'b0);

    // early resp_last in burst 0
    bad_last = 1;
    run(24'h000200, 16'h0F0F, 0, 1'b0, 16'd0, 24'h0, 1'b1);
    bad_last = 0;

    // reset during WR_DATA, then a clean run with start held while busy
    push_expect(24'h000300, 16'h5555, 1'b1, 16'd0, 24'h0, 1'b0);
    @(posedge clk); #1;
    base_addr = 24'h000300; seed = 16'h5555; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    reached = 0;
    for (int i = 0; i < 200 && !reached; i++) begin
      @(negedge clk);
      if (wr_q.size() <= NB * (BL + 1) - 4) reached = 1;
    end
    chk("reached_wr_data", 32'(reached), 32'd1);
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    wr_q.delete();
    res_q.delete();
    rstn = 1'b1;
    run(24'h000400, 16'h1357, 20, 1'b1, 16'd0, 24'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
